// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM states, reset/NOP defaults
// and the sequential next-PC helper.
package fetch_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] INSTR_BYTES       = 32'd4;

  // Sequential successor; wraps modulo 2^32.
  function automatic logic [31:0] next_pc(input logic [31:0] pc);
    return pc + INSTR_BYTES;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: load, hold or flush; flush leaves a NOP bubble.
// Priority is rst > flush > load > hold; one-cycle latency from load to output.
module if_id_reg #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic        flush_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_plus4_i,
  output logic        valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_plus4_o
);

  logic        valid_q;
  logic [31:0] instr_q;
  logic [31:0] pc_plus4_q;

  // A flush keeps pc_plus4 so the bubble still carries the last known address.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= 1'b0;
      instr_q    <= NOP_INSTR;
      pc_plus4_q <= 32'h0000_0000;
    end else if (flush_i) begin
      valid_q    <= 1'b0;
      instr_q    <= NOP_INSTR;
    end else if (load_i) begin
      valid_q    <= 1'b1;
      instr_q    <= instr_i;
      pc_plus4_q <= pc_plus4_i;
    end
  end

  assign valid_o    = valid_q;
  assign instr_o    = valid_q ? instr_q : NOP_INSTR;
  assign pc_plus4_o = pc_plus4_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: PC, FETCH/HOLD/DRAIN FSM and stall hold buffer feeding if_id_reg.
// Optional INSTR_FETCH_PERF_CNT_EN adds fetch and bubble counters.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  output logic        if_id_valid,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc_plus4
`ifdef INSTR_FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_bubble_cnt
`endif
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  hold_q, hold_d;
  logic         boot_q;

  logic         redirect;
  logic [31:0]  target;
  logic [31:0]  pc_plus4;
  logic         resp;
  logic         ld;
  logic         flush;
  logic [31:0]  ld_instr;

  assign redirect = jump | branch_taken;
  assign target   = jump ? jump_target : branch_target;
  assign pc_plus4 = next_pc(pc_q);

  // The first cycle out of reset issues no request, so a response still in
  // flight from before reset lands in a cycle where it is ignored.
  assign imem_req  = (state_q == FETCH) && !boot_q && !rst;
  assign imem_addr = pc_q;
  assign resp      = imem_req && imem_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      hold_q  <= 32'h0000_0000;
      boot_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      hold_q  <= hold_d;
      boot_q  <= 1'b0;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    hold_d   = hold_q;
    ld       = 1'b0;
    flush    = 1'b0;
    ld_instr = imem_rdata;
    unique case (state_q)
      FETCH: begin
        if (redirect) begin
          pc_d    = target;
          flush   = 1'b1;
          state_d = (imem_req && !imem_valid) ? DRAIN : FETCH;
        end else if (resp) begin
          if (stall) begin
            hold_d  = imem_rdata;
            state_d = HOLD;
          end else begin
            ld   = 1'b1;
            pc_d = pc_plus4;
          end
        end else if (!stall) begin
          flush = 1'b1;
        end
      end
      HOLD: begin
        if (redirect) begin
          pc_d    = target;
          flush   = 1'b1;
          hold_d  = 32'h0000_0000;
          state_d = FETCH;
        end else if (!stall) begin
          ld       = 1'b1;
          ld_instr = hold_q;
          pc_d     = pc_plus4;
          state_d  = FETCH;
        end
      end
      DRAIN: begin
        // The abandoned response is swallowed here; new redirects only retarget pc.
        if (redirect) begin
          pc_d  = target;
          flush = 1'b1;
        end else if (!stall) begin
          flush = 1'b1;
        end
        if (imem_valid) begin
          state_d = FETCH;
        end
      end
      default: begin
        state_d = FETCH;
        flush   = 1'b1;
      end
    endcase
  end

  if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .clk        (clk),
    .rst        (rst),
    .load_i     (ld),
    .flush_i    (flush),
    .instr_i    (ld_instr),
    .pc_plus4_i (pc_plus4),
    .valid_o    (if_id_valid),
    .instr_o    (if_id_instr),
    .pc_plus4_o (if_id_pc_plus4)
  );

`ifdef INSTR_FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] bubble_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q  <= 32'h0000_0000;
      bubble_cnt_q <= 32'h0000_0000;
    end else begin
      if (ld && !flush) begin
        fetch_cnt_q <= fetch_cnt_q + 32'd1;
      end
      if (!if_id_valid) begin
        bubble_cnt_q <= bubble_cnt_q + 32'd1;
      end
    end
  end

  assign perf_fetch_cnt  = fetch_cnt_q;
  assign perf_bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: inputs change after the falling edge, outputs are checked 1ns later.
module tb_instr_fetch;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic        if_id_valid;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc_plus4;
`ifdef INSTR_FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_bubble_cnt;
`endif

  int errors = 0;
  int checks = 0;

  localparam logic [31:0] NOP = 32'h0000_0000;

  instr_fetch #(
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (NOP)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .branch_taken   (branch_taken),
    .branch_target  (branch_target),
    .jump           (jump),
    .jump_target    (jump_target),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_valid     (imem_valid),
    .imem_rdata     (imem_rdata),
    .if_id_valid    (if_id_valid),
    .if_id_instr    (if_id_instr),
    .if_id_pc_plus4 (if_id_pc_plus4)
`ifdef INSTR_FETCH_PERF_CNT_EN
    ,
    .perf_fetch_cnt  (perf_fetch_cnt),
    .perf_bubble_cnt (perf_bubble_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic quiet();
    stall         = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 32'h0;
    jump          = 1'b0;
    jump_target   = 32'h0;
    imem_valid    = 1'b0;
    imem_rdata    = 32'h0;
  endtask

  task automatic resp(input logic [31:0] data);
    imem_valid = 1'b1;
    imem_rdata = data;
  endtask

  task automatic next_step();
    @(negedge clk);
    quiet();
  endtask

  initial begin
    rst = 1'b1;
    quiet();

    // Reset with a stale response on the bus
    next_step(); rst = 1'b1; resp(32'hDEAD_0000); #1;
    chk("rst_req", {31'b0, imem_req}, 32'd0);

    next_step(); rst = 1'b0; resp(32'hDEAD_BEEF); #1;
    chk("boot_req", {31'b0, imem_req}, 32'd0);
    chk("rst_valid", {31'b0, if_id_valid}, 32'd0);
    chk("rst_instr", if_id_instr, NOP);
    chk("rst_pc4", if_id_pc_plus4, 32'h0);

    // Back-to-back zero-wait fetches
    next_step(); resp(32'h1111_0000); #1;
    chk("seq_req0", {31'b0, imem_req}, 32'd1);
    chk("seq_addr0", imem_addr, 32'h0);
    chk("boot_resp_ignored", {31'b0, if_id_valid}, 32'd0);

    next_step(); resp(32'h1111_0004); #1;
    chk("seq_addr4", imem_addr, 32'h4);
    chk("seq_instr0", if_id_instr, 32'h1111_0000);
    chk("seq_pc4_4", if_id_pc_plus4, 32'h4);

    next_step(); resp(32'h1111_0008); #1;
    chk("seq_addr8", imem_addr, 32'h8);
    chk("seq_pc4_8", if_id_pc_plus4, 32'h8);

    next_step(); resp(32'h1111_000C); #1;
    chk("seq_addrC", imem_addr, 32'hC);
    chk("seq_pc4_C", if_id_pc_plus4, 32'hC);

    // Slow memory at 0x10: valid on the third cycle
    next_step(); #1;
    chk("slow_addr_a", imem_addr, 32'h10);
    chk("slow_valid_a", {31'b0, if_id_valid}, 32'd1);
    next_step(); #1;
    chk("slow_addr_b", imem_addr, 32'h10);
    chk("slow_valid_b", {31'b0, if_id_valid}, 32'd0);
    next_step(); resp(32'h2222_0010); #1;
    chk("slow_addr_c", imem_addr, 32'h10);
    chk("slow_req_c", {31'b0, imem_req}, 32'd1);
    chk("slow_valid_c", {31'b0, if_id_valid}, 32'd0);

    // Branch coinciding with a response: word dropped, straight to 0x1C
    next_step(); resp(32'hBAD0_0014); branch_taken = 1'b1; branch_target = 32'h1C; #1;
    chk("slow_done_valid", {31'b0, if_id_valid}, 32'd1);
    chk("slow_done_pc4", if_id_pc_plus4, 32'h14);
    chk("slow_done_instr", if_id_instr, 32'h2222_0010);

    next_step(); resp(32'h3333_001C); #1;
    chk("br_addr", imem_addr, 32'h1C);
    chk("br_flush", {31'b0, if_id_valid}, 32'd0);
    chk("br_nop", if_id_instr, NOP);

    // Stall for two cycles while 0x20 returns
    next_step(); resp(32'h4444_0020); stall = 1'b1; #1;
    chk("st_addr", imem_addr, 32'h20);
    chk("st_instr_pre", if_id_instr, 32'h3333_001C);
    next_step(); stall = 1'b1; #1;
    chk("hold_req", {31'b0, imem_req}, 32'd0);
    chk("hold_instr", if_id_instr, 32'h3333_001C);
    chk("hold_pc4", if_id_pc_plus4, 32'h20);
    next_step(); #1;
    chk("hold_req2", {31'b0, imem_req}, 32'd0);
    chk("hold_instr2", if_id_instr, 32'h3333_001C);

    // Jump coinciding with the 0x24 response, to 0x30
    next_step(); resp(32'hBAD0_0024); jump = 1'b1; jump_target = 32'h30; #1;
    chk("rel_instr", if_id_instr, 32'h4444_0020);
    chk("rel_pc4", if_id_pc_plus4, 32'h24);
    chk("rel_addr", imem_addr, 32'h24);
    chk("rel_req", {31'b0, imem_req}, 32'd1);

    // Redirect to 0x100 while 0x30 is outstanding
    next_step(); branch_taken = 1'b1; branch_target = 32'h100; #1;
    chk("dr_addr30", imem_addr, 32'h30);
    chk("dr_req30", {31'b0, imem_req}, 32'd1);
    next_step(); #1;
    chk("drain_req", {31'b0, imem_req}, 32'd0);
    chk("drain_bubble", {31'b0, if_id_valid}, 32'd0);
    next_step(); resp(32'hBAD0_0030); #1;
    chk("drain_req2", {31'b0, imem_req}, 32'd0);

    // Jump and branch together under stall, with a response
    next_step(); resp(32'hBAD0_0100); stall = 1'b1;
    jump = 1'b1; jump_target = 32'h200; branch_taken = 1'b1; branch_target = 32'h300; #1;
    chk("drain_exit_addr", imem_addr, 32'h100);
    chk("drain_exit_req", {31'b0, imem_req}, 32'd1);
    chk("late_dropped", {31'b0, if_id_valid}, 32'd0);

    next_step(); resp(32'hBAD0_0200); jump = 1'b1; jump_target = 32'hFFFF_FFFC; #1;
    chk("prio_addr", imem_addr, 32'h200);
    chk("prio_valid", {31'b0, if_id_valid}, 32'd0);

    // PC wrap at the top of the address space
    next_step(); resp(32'h5555_FFFC); #1;
    chk("wrap_addr_hi", imem_addr, 32'hFFFF_FFFC);

    next_step(); jump = 1'b1; jump_target = 32'h400; #1;
    chk("wrap_addr0", imem_addr, 32'h0);
    chk("wrap_pc4", if_id_pc_plus4, 32'h0);
    chk("wrap_instr", if_id_instr, 32'h5555_FFFC);

    // Redirect inside DRAIN, then reset mid-drain
    next_step(); branch_taken = 1'b1; branch_target = 32'h500; #1;
    chk("d2_req", {31'b0, imem_req}, 32'd0);
    chk("d2_addr", imem_addr, 32'h400);

    next_step(); rst = 1'b1; #1;
    chk("d2_retarget", imem_addr, 32'h500);
    chk("d2_rst_req", {31'b0, imem_req}, 32'd0);

    next_step(); rst = 1'b0; resp(32'hBAD0_0500); #1;
    chk("rst2_addr", imem_addr, 32'h0);
    chk("rst2_req", {31'b0, imem_req}, 32'd0);

    next_step(); resp(32'h6666_0000); #1;
    chk("rst2_stale_ignored", {31'b0, if_id_valid}, 32'd0);
    chk("rst2_req1", {31'b0, imem_req}, 32'd1);

    // Stall with no response keeps IF/ID and the request
    next_step(); stall = 1'b1; #1;
    chk("post_instr", if_id_instr, 32'h6666_0000);
    chk("post_pc4", if_id_pc_plus4, 32'h4);

    next_step(); #1;
    chk("stall_keep_valid", {31'b0, if_id_valid}, 32'd1);
    chk("stall_keep_instr", if_id_instr, 32'h6666_0000);
    chk("stall_keep_addr", imem_addr, 32'h4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
